regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port between several writeback sources (ALU, load unit, multi-cycle units). Each source gets a valid/ready handshake, and a round-robin arbiter picks which one wins the port. The winner's write is registered onto the register file's RegWrite/rd/write_data inputs. The block also keeps a per-register busy scoreboard: the issue stage reserves a destination, and the matching writeback clears it, so decode can detect RAW/WAW hazards and stall.

---
 rtl/regfile_wb_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Writeback request bundle: one valid/ready/addr/data lane per requester.
// The arbiter takes the slave side; the writeback units drive the master side.
interface regfile_wb_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of the register file write port among writeback units,
// plus a per-register busy scoreboard used by issue/decode for hazard detection.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_if.slave      wb,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ok,
    input  logic [AW-1:0]    chk_addr1,
    input  logic [AW-1:0]    chk_addr2,
    output logic             chk_busy1,
    output logic             chk_busy2,
    output logic             RegWrite,
    output logic [AW-1:0]    rd,
    output logic [DW-1:0]    write_data,
    output logic [2**AW-1:0] busy
);
    localparam int NR = 2**AW;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [NR-1:0] busy_q, busy_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_data;
    logic          rsv_hit;
    logic          rsv_take;

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p,
                                             input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && wb.req_valid[rr_idx(ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr_q, k);
            end
        end
    end

    assign gnt_addr = wb.req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data = wb.req_data[int'(gnt_idx)*DW +: DW];

    always_comb begin
        wb.req_ready = '0;
        if (gnt_any && !rst) wb.req_ready[gnt_idx] = 1'b1;
    end

    // A reservation may piggyback on a same-cycle writeback of that register.
    assign rsv_hit  = gnt_any && (gnt_addr == rsv_addr);
    assign rsv_ok   = (rsv_addr == '0) || !busy_q[rsv_addr] || rsv_hit;
    assign rsv_take = rsv_valid && rsv_ok && (rsv_addr != '0);

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Clear first so that a simultaneous reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) busy_d[gnt_addr] = 1'b0;
        if (rsv_take) busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        regwrite_d = gnt_any && (gnt_addr != '0);
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (gnt_any) begin
            rd_d    = gnt_addr;
            wdata_d = gnt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign chk_busy1  = busy_q[chk_addr1];
    assign chk_busy2  = busy_q[chk_addr2];
    assign RegWrite   = regwrite_q;
    assign rd         = rd_q;
    assign write_data = wdata_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus hand-written reset sequence for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ok;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        chk_busy1, chk_busy2;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] busy;

    int checks;
    int failures;

    regfile_wb_if #(.NREQ(3), .DW(32), .AW(5)) wb ();

    regfile_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rsv_ok     (rsv_ok),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .write_data (write_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  rv;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        rsv;
        logic [4:0]  ra, c1, c2;
        logic [2:0]  ready;
        logic        rok, cb1, cb2;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] busy;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb.req_valid = v.rv;
        wb.req_addr  = {v.a2, v.a1, v.a0};
        wb.req_data  = {v.d2, v.d1, v.d0};
        rsv_valid    = v.rsv;
        rsv_addr     = v.ra;
        chk_addr1    = v.c1;
        chk_addr2    = v.c2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // rv a0 a1 a2 d0 d1 d2 rsv ra c1 c2 | ready rok cb1 cb2 | rw rd wd busy
        tv.push_back('{3'b001, 5'd5, 5'd0, 5'd0, 32'hA5, 32'h0, 32'h0,
                       1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0,
                       1'b1, 5'd5, 32'hA5, 32'h0});
        tv.push_back('{3'b000, 5'd5, 5'd0, 5'd0, 32'hA5, 32'h0, 32'h0,
                       1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0,
                       1'b0, 5'd5, 32'hA5, 32'h0});
        tv.push_back('{3'b010, 5'd0, 5'd6, 5'd0, 32'h0, 32'h66, 32'h0,
                       1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b0,
                       1'b1, 5'd6, 32'h66, 32'h0});
        tv.push_back('{3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h99,
                       1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0,
                       1'b1, 5'd9, 32'h99, 32'h0});
        for (int r = 0; r < 2; r++) begin
            tv.push_back('{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                           1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0,
                           1'b1, 5'd1, 32'h11, 32'h0});
            tv.push_back('{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                           1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 1'b0, 1'b0,
                           1'b1, 5'd2, 32'h22, 32'h0});
            tv.push_back('{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                           1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0,
                           1'b1, 5'd3, 32'h33, 32'h0});
        end
        tv.push_back('{3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                       1'b1, 5'd7, 5'd7, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0,
                       1'b0, 5'd3, 32'h33, 32'h80});
        tv.push_back('{3'b000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                       1'b1, 5'd7, 5'd7, 5'd5, 3'b000, 1'b0, 1'b1, 1'b0,
                       1'b0, 5'd3, 32'h33, 32'h80});
        tv.push_back('{3'b010, 5'd1, 5'd7, 5'd3, 32'h11, 32'h77, 32'h33,
                       1'b0, 5'd0, 5'd7, 5'd0, 3'b010, 1'b1, 1'b1, 1'b0,
                       1'b1, 5'd7, 32'h77, 32'h0});
        tv.push_back('{3'b000, 5'd1, 5'd7, 5'd3, 32'h11, 32'h77, 32'h33,
                       1'b1, 5'd7, 5'd7, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0,
                       1'b0, 5'd7, 32'h77, 32'h80});
        tv.push_back('{3'b100, 5'd1, 5'd7, 5'd7, 32'h11, 32'h77, 32'h77770007,
                       1'b1, 5'd7, 5'd7, 5'd0, 3'b100, 1'b1, 1'b1, 1'b0,
                       1'b1, 5'd7, 32'h77770007, 32'h80});
        tv.push_back('{3'b001, 5'd0, 5'd7, 5'd7, 32'hFFFFFFFF, 32'h77, 32'h77770007,
                       1'b1, 5'd0, 5'd0, 5'd7, 3'b001, 1'b1, 1'b0, 1'b1,
                       1'b0, 5'd0, 32'hFFFFFFFF, 32'h80});
        tv.push_back('{3'b001, 5'd7, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0,
                       1'b0, 5'd0, 5'd7, 5'd0, 3'b001, 1'b1, 1'b1, 1'b0,
                       1'b1, 5'd7, 32'h1, 32'h0});

        rst          = 1'b1;
        wb.req_valid = 3'b111;
        wb.req_addr  = '0;
        wb.req_data  = '0;
        rsv_valid    = 1'b0;
        rsv_addr     = 5'd0;
        chk_addr1    = 5'd0;
        chk_addr2    = 5'd0;
        #2;
        chk("rst_ready", 0, 32'(wb.req_ready), 32'h0);
        chk("rst_regwrite", 0, 32'(RegWrite), 32'h0);
        chk("rst_rd", 0, 32'(rd), 32'h0);
        chk("rst_wdata", 0, write_data, 32'h0);
        chk("rst_busy", 0, busy, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            @(negedge clk);
            chk("ready", i, 32'(wb.req_ready), 32'(tv[i].ready));
            chk("rsv_ok", i, 32'(rsv_ok), 32'(tv[i].rok));
            chk("chk_busy1", i, 32'(chk_busy1), 32'(tv[i].cb1));
            chk("chk_busy2", i, 32'(chk_busy2), 32'(tv[i].cb2));
            @(posedge clk);
            #1;
            chk("regwrite", i, 32'(RegWrite), 32'(tv[i].rw));
            chk("rd", i, 32'(rd), 32'(tv[i].rd));
            chk("wdata", i, write_data, tv[i].wd);
            chk("busy", i, busy, tv[i].busy);
        end

        // Mid-cycle reset with a write landing and r3 reserved.
        wb.req_valid = 3'b001;
        wb.req_addr  = {5'd0, 5'd0, 5'd4};
        wb.req_data  = {32'h0, 32'h0, 32'h44};
        rsv_valid    = 1'b1;
        rsv_addr     = 5'd3;
        @(posedge clk);
        #1;
        rsv_valid = 1'b0;
        chk("pre_rst_regwrite", 0, 32'(RegWrite), 32'h1);
        chk("pre_rst_busy", 0, busy, 32'h8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", 0, 32'(wb.req_ready), 32'h0);
        chk("async_regwrite", 0, 32'(RegWrite), 32'h0);
        chk("async_rd", 0, 32'(rd), 32'h0);
        chk("async_wdata", 0, write_data, 32'h0);
        chk("async_busy", 0, busy, 32'h0);
        wb.req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        wb.req_valid = 3'b011;
        wb.req_addr  = {5'd0, 5'd8, 5'd4};
        wb.req_data  = {32'h0, 32'h88, 32'h44};
        #1;
        chk("post_rst_ready", 0, 32'(wb.req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("post_rst_regwrite", 0, 32'(RegWrite), 32'h1);
        chk("post_rst_rd", 0, 32'(rd), 32'h4);
        chk("post_rst_wdata", 0, write_data, 32'h44);
        wb.req_valid = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
